// File: rtl/bin2bcd_seq.sv
// Converts an unsigned binary value to two BCD digits plus an overflow flag, one bit per clock.
// Latency: done is high WIDTH cycles after the accepting edge; start is ignored while busy.
module bin2bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_sr;
  logic [11:0]         r_bcd;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_tens;
  logic [3:0]          r_ones;
  logic                r_ovf;
  logic                r_done;

  logic                w_load;
  logic                w_step;
  logic                w_last;
  logic [11:0]         w_adj;
  logic [WIDTH+11:0]   w_all;
  logic [WIDTH+11:0]   w_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(WIDTH - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    busy   = 1'b0;
    case (r_state)
      IDLE:  w_load = start;
      SHIFT: begin
        w_step = 1'b1;
        w_last = (r_cnt == CW'(WIDTH - 1));
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Add-3 correction on every nibble, then one combined left shift of {bcd, sr}.
  always_comb begin
    w_adj[3:0]   = (r_bcd[3:0]   >= 4'd5) ? r_bcd[3:0]   + 4'd3 : r_bcd[3:0];
    w_adj[7:4]   = (r_bcd[7:4]   >= 4'd5) ? r_bcd[7:4]   + 4'd3 : r_bcd[7:4];
    w_adj[11:8]  = (r_bcd[11:8]  >= 4'd5) ? r_bcd[11:8]  + 4'd3 : r_bcd[11:8];
    w_all        = {w_adj, r_sr};
    w_shifted    = w_all << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_tens <= '0;
      r_ones <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sr  <= bin;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_sr  <= w_shifted[WIDTH-1:0];
        r_bcd <= w_shifted[WIDTH+11:WIDTH];
        r_cnt <= r_cnt + 1'b1;
      end
      // Display digits only move on the final edge so no partial result is ever shown.
      if (w_last) begin
        r_tens <= w_shifted[WIDTH+7:WIDTH+4];
        r_ones <= w_shifted[WIDTH+3:WIDTH];
        r_ovf  <= (w_shifted[WIDTH+11:WIDTH+8] != 4'd0);
      end
    end
  end

  assign done = r_done;
  assign tens = r_tens;
  assign ones = r_ones;
  assign ovf  = r_ovf;

endmodule
